// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I ALU-subset encodings, alu_op codes and decode helper.
package rv32i_pkg;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef struct packed {
    logic       legal;
    logic       is_r;
    logic [3:0] alu_op;
  } dec_t;

  // Illegal encodings come back with alu_op = ALU_ADD so downstream sees a benign op.
  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic [6:0] funct7);
    dec_t d;
    logic [3:0] f3_op;
    logic       f3_ok;
    d      = '0;
    f3_ok  = 1'b1;
    f3_op  = ALU_ADD;
    case (funct3)
      F3_ADD:  f3_op = ALU_ADD;
      F3_AND:  f3_op = ALU_AND;
      F3_OR:   f3_op = ALU_OR;
      F3_XOR:  f3_op = ALU_XOR;
      default: f3_ok = 1'b0;
    endcase
    if (opcode == OP_REG) begin
      if (funct7 == F7_BASE && f3_ok) begin
        d.legal  = 1'b1;
        d.is_r   = 1'b1;
        d.alu_op = f3_op;
      end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
        d.legal  = 1'b1;
        d.is_r   = 1'b1;
        d.alu_op = ALU_SUB;
      end
    end else if (opcode == OP_IMM && f3_ok) begin
      d.legal  = 1'b1;
      d.alu_op = f3_op;
    end
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file, x0 hardwired to zero, write-to-read bypass.
module regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode/operand-fetch stage with busy-bit scoreboard and 1-entry output register.
module operand_fetch
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_op2,
  output logic [3:0]      ex_alu_op,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic            ex_illegal,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  logic [4:0]      rs1, rs2, rd;
  dec_t            dec;
  logic            rd_we_d;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, op2_d;
  logic [NREG-1:0] busy, busy_next, clr_mask, live;
  logic            wb_clr, hazard, accept;

  assign rs1     = in_instr[19:15];
  assign rs2     = in_instr[24:20];
  assign rd      = in_instr[11:7];
  assign dec     = decode(in_instr[6:0], in_instr[14:12], in_instr[31:25]);
  assign rd_we_d = dec.legal && rd != 5'd0;
  assign imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign op2_d   = !dec.legal ? '0 : (dec.is_r ? rs2_val : imm);

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // A register being written back this cycle is no longer a hazard.
  assign wb_clr   = wb_we && wb_rd != 5'd0;
  assign clr_mask = wb_clr ? (NREG'(1) << wb_rd) : '0;
  assign live     = busy & ~clr_mask;
  assign hazard   = dec.legal && (live[rs1] || (dec.is_r && live[rs2]) || (rd_we_d && live[rd]));
  assign in_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_next = live;
    if (flush && ex_valid && ex_rd_we) busy_next[ex_rd] = 1'b0;
    if (accept && rd_we_d) busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_rs1_val <= '0;
      ex_op2     <= '0;
      ex_alu_op  <= ALU_ADD;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_rs1_val <= rs1_val;
      ex_op2     <= op2_d;
      ex_alu_op  <= dec.alu_op;
      ex_rd      <= rd;
      ex_rd_we   <= rd_we_d;
      ex_illegal <= !dec.legal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed plus randomized bench for operand_fetch against a behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ex_valid, ex_ready, ex_rd_we, ex_illegal;
  logic        wb_we, flush;
  logic [31:0] in_instr, ex_rs1_val, ex_op2, wb_data;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd, wb_rd;

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1_val(ex_rs1_val), .ex_op2(ex_op2),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: architectural registers, set of in-flight writers, and the pending ALU operation.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_valid, m_we, m_ill;
  logic [31:0] m_rs1, m_op2;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {im, s1, f3, d, 7'b0010011};
  endfunction

  // Supported mnemonics: funct3 000/111/110/100 -> ADD/AND/OR/XOR (0,2,3,4); SUB = 1.
  function automatic void mdec(input logic [31:0] i, output bit legal, output bit is_r,
                               output logic [3:0] op);
    bit f3ok;
    logic [3:0] f3op;
    f3ok = 1; f3op = 0; legal = 0; is_r = 0; op = 0;
    case (i[14:12])
      3'd0: f3op = 4'd0;
      3'd7: f3op = 4'd2;
      3'd6: f3op = 4'd3;
      3'd4: f3op = 4'd4;
      default: f3ok = 0;
    endcase
    if (i[6:0] == 7'h33) begin
      is_r = 1;
      if (i[31:25] == 7'h00 && f3ok) begin legal = 1; op = f3op; end
      else if (i[31:25] == 7'h20 && i[14:12] == 3'd0) begin legal = 1; op = 4'd1; end
    end else if (i[6:0] == 7'h13 && f3ok) begin
      legal = 1; op = f3op;
    end
    if (!legal) is_r = 0;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit live(input logic [4:0] r);
    return m_busy[r] && !(wb_we && wb_rd == r && r != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_busy = 0; m_valid = 0; m_we = 0; m_ill = 0;
    m_rs1 = 0; m_op2 = 0; m_op = 0; m_rd = 0;
  endtask

  // One clock: check in_ready mid-cycle, advance the model, then check registered outputs.
  task automatic step();
    bit legal, is_r, hz, exp_rdy, acc;
    logic [3:0]  op;
    logic [4:0]  s1, s2, d;
    logic [31:0] v1, v2;
    @(negedge clk);
    last_ready = in_ready;
    if (rst) begin
      model_reset();
    end else begin
      mdec(in_instr, legal, is_r, op);
      s1 = in_instr[19:15]; s2 = in_instr[24:20]; d = in_instr[11:7];
      hz = legal && (live(s1) || (is_r && live(s2)) || (d != 0 && live(d)));
      exp_rdy = (!m_valid || ex_ready) && !hz && !flush;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = in_valid && exp_rdy;
      v1 = mread(s1);
      v2 = is_r ? mread(s2) : {{20{in_instr[31]}}, in_instr[31:20]};
      if (wb_we && wb_rd != 0) begin m_regs[wb_rd] = wb_data; m_busy[wb_rd] = 0; end
      if (flush && m_valid && m_we) m_busy[m_rd] = 0;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_rs1 = v1; m_op2 = legal ? v2 : 0; m_op = legal ? op : 0;
        m_rd = d; m_we = legal && d != 0; m_ill = !legal;
        if (m_we) m_busy[d] = 1;
      end else if (ex_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("busy", dut.busy, m_busy);
    if (m_valid) begin
      chk("ex_op2", ex_op2, m_op2);
      chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, m_op});
      chk("ex_rd_we", {31'd0, ex_rd_we}, {31'd0, m_we});
      chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ill});
      if (!m_ill) begin
        chk("ex_rs1_val", ex_rs1_val, m_rs1);
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      end
    end
  endtask

  task automatic idle();
    in_valid = 0; wb_we = 0; flush = 0; ex_ready = 1; rst = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_we = 1; wb_rd = r; wb_data = v;
    step();
    wb_we = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3s [4];
    logic [4:0] a, b, c;
    int k;
    f3s[0] = 3'd0; f3s[1] = 3'd7; f3s[2] = 3'd6; f3s[3] = 3'd4;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    if (k <= 3) return rtype(7'h00, b, a, f3s[$urandom_range(0, 3)], c);
    if (k == 4) return rtype(7'h20, b, a, 3'd0, c);
    if (k <= 7) return itype(12'($urandom), a, f3s[$urandom_range(0, 3)], c);
    if (k == 8) return {17'($urandom), 3'd2, c, 7'b0000011};
    return $urandom;
  endfunction

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; ex_ready = 1; wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
    model_reset();
    step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_rs1", ex_rs1_val, 32'd0);
    chk("rst_op2", ex_op2, 32'd0);
    chk("rst_fields", {22'd0, ex_alu_op, ex_rd, ex_rd_we}, 32'd0);
    idle();

    wb(5, 32'd7);
    wb(6, 32'd3);
    in_valid = 1; in_instr = 32'h006283B3;
    step();
    chk("add_rs1", ex_rs1_val, 32'd7);
    chk("add_op2", ex_op2, 32'd3);
    chk("add_rd", {27'd0, ex_rd}, 32'd7);
    in_valid = 0;
    wb(7, 32'd10);

    in_valid = 1; in_instr = rtype(7'h20, 6, 5, 3'd0, 7);
    step();
    chk("sub_op", {28'd0, ex_alu_op}, 32'd1);
    in_instr = itype(12'hFFF, 7, 3'd0, 8);
    step();
    chk("raw_stall_a", {31'd0, last_ready}, 32'd0);
    step();
    chk("raw_stall_b", {31'd0, last_ready}, 32'd0);
    wb_we = 1; wb_rd = 7; wb_data = 32'd4;
    step();
    wb_we = 0;
    chk("raw_release", {31'd0, last_ready}, 32'd1);
    chk("bypass_rs1", ex_rs1_val, 32'd4);
    chk("addi_imm", ex_op2, 32'hFFFF_FFFF);

    ex_ready = 0; in_instr = rtype(7'h00, 6, 5, 3'd4, 11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ready", {31'd0, last_ready}, 32'd0);
      chk("hold_rs1", ex_rs1_val, 32'd4);
    end
    ex_ready = 1;
    step();
    chk("xor_op", {28'd0, ex_alu_op}, 32'd4);
    in_valid = 0;
    wb(8, 32'd3);
    wb(11, 32'd4);

    in_valid = 1; in_instr = itype(12'h7FF, 1, 3'd4, 0);
    step();
    chk("xori_x0_we", {31'd0, ex_rd_we}, 32'd0);
    in_instr = rtype(7'h00, 0, 0, 3'd0, 2);
    step();
    chk("add_x0_ready", {31'd0, last_ready}, 32'd1);
    chk("add_x0_ops", ex_rs1_val | ex_op2, 32'd0);

    in_instr = 32'h0000_2083;
    step();
    chk("load_illegal", {31'd0, ex_illegal}, 32'd1);
    in_valid = 0; ex_ready = 0; flush = 1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 0; ex_ready = 1;

    in_valid = 1; in_instr = itype(12'd5, 5, 3'd7, 9);
    step();
    in_valid = 0; ex_ready = 0; flush = 1;
    step();
    chk("flush_busy9", {31'd0, dut.busy[9]}, 32'd0);
    flush = 0; ex_ready = 1; in_valid = 1; in_instr = rtype(7'h00, 9, 9, 3'd0, 10);
    step();
    chk("post_flush_ready", {31'd0, last_ready}, 32'd1);
    in_instr = itype(12'd1, 10, 3'd0, 12);
    step();
    chk("stall_before_rst", {31'd0, last_ready}, 32'd0);
    rst = 1;
    step();
    chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_busy", dut.busy, 32'd0);
    idle();

    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = rand_instr();
      ex_ready = $urandom_range(0, 3) != 0;
      wb_we    = $urandom_range(0, 2) == 0;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = $urandom_range(0, 15) == 0;
      rst      = $urandom_range(0, 199) == 0;
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
